// File: rtl/ahb_uart_tx.sv
// rtl/ahb_uart_tx.sv - AHB-Lite slave UART transmitter with byte FIFO and programmable bit divisor.
// Optional macro AHB_UART_TXIRQ_EN adds the irq output and the STATUS IE bit.
module ahb_uart_tx #(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 16
) (
    input  logic        wclk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP,
    output logic        txd
`ifdef AHB_UART_TXIRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST_C = 16'(DIV_RESET);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic          dp_sel;
    logic          dp_wr;
    logic [1:0]    dp_addr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovf;
    logic [15:0]   div_reg;
    logic          ie_rd;
    state_t        state;
    logic [15:0]   bit_div;
    logic [15:0]   cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic        full, empty, busy, wr_en, push_req, push, pop;
    logic [15:0] eff_div;

    wire unused_bits = &{1'b0, HSIZE, HADDR[31:4], HADDR[1:0], HWDATA};

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign busy     = (state != S_IDLE);
    assign wr_en    = dp_sel & dp_wr;
    assign push_req = wr_en & (dp_addr == 2'd0);
    // A pop happens on the edge where the transmitter loads a new frame.
    assign pop      = ~empty & ((state == S_IDLE) | ((state == S_STOP) & (cnt == 16'd0)));
    assign push     = push_req & (~full | pop);
    assign eff_div  = (div_reg < 16'd2) ? 16'd2 : div_reg;

`ifdef AHB_UART_TXIRQ_EN
    logic ie;
    assign ie_rd = ie;
    assign irq   = ie & empty & ~busy;
`else
    assign ie_rd = 1'b0;
`endif

    always_comb begin
        HRDATA = 32'd0;
        if (dp_sel && !dp_wr) begin
            case (dp_addr)
                2'd1:    HRDATA = {27'd0, ie_rd, ovf, busy, empty, full};
                2'd2:    HRDATA = {16'd0, div_reg};
                default: HRDATA = 32'd0;
            endcase
        end
    end

    always_ff @(posedge wclk) begin
        if (push) begin
            mem[wr_ptr] <= HWDATA[7:0];
        end
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            dp_sel  <= 1'b0;
            dp_wr   <= 1'b0;
            dp_addr <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            div_reg <= DIV_RST_C;
`ifdef AHB_UART_TXIRQ_EN
            ie      <= 1'b0;
`endif
        end else begin
            if (HREADY) begin
                dp_sel  <= HSEL & HTRANS[1];
                dp_wr   <= HWRITE;
                dp_addr <= HADDR[3:2];
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (wr_en && dp_addr == 2'd1) begin
                if (HWDATA[3]) begin
                    ovf <= 1'b0;
                end
`ifdef AHB_UART_TXIRQ_EN
                ie <= HWDATA[4];
`endif
            end
            // Placed after the clear so a coincident overflow keeps the bit set.
            if (push_req && !push) begin
                ovf <= 1'b1;
            end
            if (wr_en && dp_addr == 2'd2) begin
                div_reg <= HWDATA[15:0];
            end
        end
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            txd     <= 1'b1;
            bit_div <= 16'd2;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (!empty) begin
                        shreg   <= mem[rd_ptr];
                        bit_div <= eff_div;
                        cnt     <= eff_div - 16'd1;
                        txd     <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == 16'd0) begin
                        cnt     <= bit_div - 16'd1;
                        bit_idx <= 3'd0;
                        txd     <= shreg[0];
                        state   <= S_DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= bit_div - 16'd1;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt == 16'd0) begin
                        if (!empty) begin
                            shreg   <= mem[rd_ptr];
                            bit_div <= eff_div;
                            cnt     <= eff_div - 16'd1;
                            txd     <= 1'b0;
                            state   <= S_START;
                        end else begin
                            txd   <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    txd   <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
